bill_pay_ctrl: RTL and testbench

BILL_PAY_CTRL -- requirements
Module: bill_pay_ctrl

---
 rtl/bill_pay_ctrl.sv | 150 +++++++++++++++
 tb/tb_bill_pay_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bill_pay_ctrl.sv
// Bill payment controller: a scanned bill is settled from account credit, cash notes or one cheque.
// Registered outputs one cycle after each input pulse; no backpressure, pulses outside their state are ignored.
module bill_pay_ctrl #(
    parameter int AMT_W   = 16,
    parameter int ACCT_W  = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_vld,
    input  logic [ACCT_W-1:0] scan_acct,
    input  logic [AMT_W-1:0]  scan_amt,
    input  logic              mode_cash,
    input  logic              mode_cheq,
    input  logic              note_vld,
    input  logic [AMT_W-1:0]  note_val,
    input  logic              cheq_vld,
    input  logic [AMT_W-1:0]  cheq_amt,
    input  logic              stop,
    output logic [AMT_W-1:0]  bal,
    output logic [AMT_W-1:0]  excess,
    output logic              done,
    output logic              short,
    output logic              note_rej,
    output logic [2:0]        state
);
    localparam int NACCT = 2 ** ACCT_W;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INFO  = 3'd1,
        S_CASH  = 3'd2,
        S_CHEQ  = 3'd3,
        S_SHORT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   bal_d, excess_d;
    logic               done_d, short_d, rej_d;
    logic [ACCT_W-1:0]  acct_q, acct_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AMT_W-1:0]   credit [NACCT];
    logic               wr_en;
    logic [ACCT_W-1:0]  wr_addr;
    logic [AMT_W-1:0]   wr_data;

    logic [AMT_W-1:0]   scan_credit, cur_credit, pay_amt, overpay, credit_new;
    logic [AMT_W:0]     credit_sum;
    logic               pay_vld, pay_ok, expired;

    function automatic logic note_ok(input logic [AMT_W-1:0] v);
        return (v == AMT_W'(1000)) || (v == AMT_W'(500)) || (v == AMT_W'(100)) ||
               (v == AMT_W'(50))   || (v == AMT_W'(20))  || (v == AMT_W'(10))  ||
               (v == AMT_W'(5));
    endfunction

    assign scan_credit = credit[scan_acct];
    assign cur_credit  = credit[acct_q];
    assign pay_amt     = (state_q == S_CASH) ? note_val : cheq_amt;
    assign pay_vld     = (state_q == S_CASH) ? note_vld : cheq_vld;
    assign pay_ok      = (state_q == S_CASH) ? note_ok(note_val) : (cheq_amt != '0);
    // Overpayment is only meaningful once pay_amt >= bal has been established.
    assign overpay     = (pay_amt >= bal) ? (pay_amt - bal) : '0;
    assign credit_sum  = {1'b0, cur_credit} + {1'b0, overpay};
    assign credit_new  = credit_sum[AMT_W] ? '1 : credit_sum[AMT_W-1:0];
    assign expired     = !(note_vld || cheq_vld) && (cnt_q == CNT_LAST);
    assign state       = state_q;

    always_comb begin
        state_d  = state_q;
        bal_d    = bal;
        excess_d = excess;
        rej_d    = 1'b0;
        acct_d   = acct_q;
        cnt_d    = (note_vld || cheq_vld) ? '0 : cnt_q + CNT_W'(1);
        wr_en    = 1'b0;
        wr_addr  = acct_q;
        wr_data  = credit_new;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (scan_vld) begin
                    acct_d  = scan_acct;
                    wr_en   = 1'b1;
                    wr_addr = scan_acct;
                    if (scan_credit >= scan_amt) begin
                        wr_data = scan_credit - scan_amt;
                        bal_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        wr_data = '0;
                        bal_d   = scan_amt - scan_credit;
                        state_d = S_INFO;
                    end
                    excess_d = wr_data;
                end
            end
            S_INFO: begin
                if (mode_cash)           state_d = S_CASH;
                else if (mode_cheq)      state_d = S_CHEQ;
                else if (stop || expired) state_d = S_SHORT;
            end
            S_CASH, S_CHEQ: begin
                if (pay_vld && pay_ok && (pay_amt >= bal)) begin
                    wr_en    = 1'b1;
                    excess_d = credit_new;
                    bal_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    if (pay_vld && pay_ok)  bal_d = bal - pay_amt;
                    if (pay_vld && !pay_ok) rej_d = 1'b1;
                    // A partial cheque ends the transaction: one instrument only.
                    if (stop || expired || (state_q == S_CHEQ && pay_vld && pay_ok))
                        state_d = S_SHORT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        done_d  = (state_d == S_DONE);
        short_d = (state_d == S_SHORT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bal      <= '0;
            excess   <= '0;
            done     <= 1'b0;
            short    <= 1'b0;
            note_rej <= 1'b0;
            acct_q   <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < NACCT; i++) credit[i] <= '0;
        end else begin
            state_q  <= state_d;
            bal      <= bal_d;
            excess   <= excess_d;
            done     <= done_d;
            short    <= short_d;
            note_rej <= rej_d;
            acct_q   <= acct_d;
            cnt_q    <= cnt_d;
            if (wr_en) credit[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_bill_pay_ctrl.sv
// Bench for bill_pay_ctrl: directed scenarios plus randomized transactions against a transaction-level model.
module tb_bill_pay_ctrl;
    localparam int TMO    = 8;
    localparam int MAXAMT = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_vld = 1'b0, mode_cash = 1'b0, mode_cheq = 1'b0;
    logic        note_vld = 1'b0, cheq_vld = 1'b0, stop = 1'b0;
    logic [3:0]  scan_acct = '0;
    logic [15:0] scan_amt = '0, note_val = '0, cheq_amt = '0;
    logic [15:0] bal, excess;
    logic        done, short, note_rej;
    logic [2:0]  state;

    always #5 clk = ~clk;

    bill_pay_ctrl #(.AMT_W(16), .ACCT_W(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .scan_vld(scan_vld), .scan_acct(scan_acct), .scan_amt(scan_amt),
        .mode_cash(mode_cash), .mode_cheq(mode_cheq), .note_vld(note_vld), .note_val(note_val),
        .cheq_vld(cheq_vld), .cheq_amt(cheq_amt), .stop(stop), .bal(bal), .excess(excess),
        .done(done), .short(short), .note_rej(note_rej), .state(state)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: per-account credit, open bill balance, and which phase the transaction is in
    // (0 idle, 1 awaiting mode, 2 cash, 3 cheque, 4 underpaid, 5 paid).
    int m_credit [16];
    int m_bal, m_excess, m_state, m_acct;
    bit m_rej;
    int notes [7] = '{1000, 500, 100, 50, 20, 10, 5};
    int bad   [5] = '{0, 7, 99, 200, 1001};

    function automatic bit is_note(int v);
        foreach (notes[i]) if (notes[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".state"},    32'(state),    m_state);
        chk({tag, ".bal"},      32'(bal),      m_bal);
        chk({tag, ".excess"},   32'(excess),   m_excess);
        chk({tag, ".done"},     32'(done),     (m_state == 5) ? 1 : 0);
        chk({tag, ".short"},    32'(short),    (m_state == 4) ? 1 : 0);
        chk({tag, ".note_rej"}, 32'(note_rej), m_rej ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        scan_vld = 1'b0; mode_cash = 1'b0; mode_cheq = 1'b0;
        note_vld = 1'b0; cheq_vld = 1'b0; stop = 1'b0;
    endtask

    function automatic void m_begin();
        m_rej = 1'b0;
        if (m_state == 4 || m_state == 5) m_state = 0;
    endfunction

    function automatic void m_reset();
        foreach (m_credit[i]) m_credit[i] = 0;
        m_bal = 0; m_excess = 0; m_state = 0; m_acct = 0; m_rej = 1'b0;
    endfunction

    function automatic void m_pay(int v, bit ok, bit s, bit is_cheq);
        int c;
        if (ok && v >= m_bal) begin
            c = m_credit[m_acct] + v - m_bal;
            m_credit[m_acct] = (c > MAXAMT) ? MAXAMT : c;
            m_excess = m_credit[m_acct];
            m_bal = 0;
            m_state = 5;
        end else begin
            if (ok) m_bal = m_bal - v;
            else m_rej = 1'b1;
            if (s || (is_cheq && ok)) m_state = 4;
        end
    endfunction

    task automatic t_scan(int a, int amt);
        scan_vld = 1'b1; scan_acct = 4'(a); scan_amt = 16'(amt);
        cycle();
        m_begin();
        if (m_state == 0) begin
            m_acct = a;
            if (m_credit[a] >= amt) begin
                m_credit[a] = m_credit[a] - amt;
                m_bal = 0; m_state = 5;
            end else begin
                m_bal = amt - m_credit[a];
                m_credit[a] = 0; m_state = 1;
            end
            m_excess = m_credit[a];
        end
        check_all("scan");
    endtask

    task automatic t_mode(bit c, bit q);
        mode_cash = c; mode_cheq = q;
        cycle();
        m_begin();
        if (m_state == 1) m_state = c ? 2 : (q ? 3 : 1);
        check_all("mode");
    endtask

    task automatic t_note(int v, bit s);
        note_vld = 1'b1; note_val = 16'(v); stop = s;
        cycle();
        m_begin();
        m_pay(v, is_note(v), s, 1'b0);
        check_all("note");
    endtask

    task automatic t_cheq(int v, bit s);
        cheq_vld = 1'b1; cheq_amt = 16'(v); stop = s;
        cycle();
        m_begin();
        m_pay(v, v != 0, s, 1'b1);
        check_all("cheq");
    endtask

    task automatic t_stop();
        stop = 1'b1;
        cycle();
        m_begin();
        if (m_state >= 1 && m_state <= 3) m_state = 4;
        check_all("stop");
    endtask

    task automatic t_idle();
        cycle();
        m_begin();
        check_all("idle");
    endtask

    initial begin : main
        int a, amt, r, n;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset");

        // Exact cash payment
        t_scan(2, 100); t_mode(1, 0); t_note(50, 0);
        chk("r34.bal_half", 32'(bal), 50);
        t_note(50, 0);
        chk("r34.done", 32'(done), 1);
        chk("r34.excess", 32'(excess), 0);
        t_idle();

        // Overpay carried as credit, then bill settled from credit alone
        t_scan(3, 120); t_mode(1, 0); t_note(500, 0);
        chk("r35.excess1", 32'(excess), 380);
        t_idle();
        t_scan(3, 100);
        chk("r35.state", 32'(state), 5);
        chk("r35.excess2", 32'(excess), 280);
        t_idle();

        // Rejected note, then a note together with stop
        t_scan(5, 100); t_mode(1, 0); t_note(7, 0);
        chk("r36.rej", 32'(note_rej), 1);
        t_note(20, 1);
        chk("r36.bal", 32'(bal), 80);
        chk("r36.short", 32'(short), 1);
        t_idle();

        // Partial cheque, zero cheque, both modes at once, max-size cheque, zero bill
        t_scan(6, 300); t_mode(0, 1); t_cheq(200, 0);
        chk("r37.bal", 32'(bal), 100);
        t_idle();
        t_scan(7, 50); t_mode(0, 1); t_cheq(0, 0);
        chk("r37.rej", 32'(note_rej), 1);
        t_stop(); t_idle();
        t_scan(4, 30); t_mode(1, 1);
        chk("both.cash_wins", 32'(state), 2);
        t_note(10, 0); t_stop(); t_idle();
        t_scan(8, 1); t_mode(0, 1); t_cheq(MAXAMT, 0);
        chk("maxcheq.excess", 32'(excess), MAXAMT - 1);
        t_idle();
        t_scan(12, 0); t_idle();

        for (int t = 0; t < 60; t++) begin
            a = $urandom_range(0, 3);
            amt = $urandom_range(0, 1200);
            t_scan(a, amt);
            if (m_state == 1) begin
                r = $urandom_range(0, 9);
                if (r == 0) t_stop();
                else if (r == 1) t_mode(1, 1);
                else if (r < 6) t_mode(1, 0);
                else t_mode(0, 1);
            end
            n = 0;
            while ((m_state == 2 || m_state == 3) && n < 30) begin
                if (m_state == 2)
                    t_note(($urandom_range(0, 4) == 0) ? bad[$urandom_range(0, 4)]
                                                       : notes[$urandom_range(0, 6)],
                           $urandom_range(0, 9) == 0);
                else
                    t_cheq(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 1500),
                           $urandom_range(0, 9) == 0);
                n++;
            end
            if (m_state == 2 || m_state == 3) t_stop();
            t_idle();
        end

        // Inactivity in CASH ends the transaction after TMO cycles
        t_scan(9, 500); t_mode(1, 0);
        n = 0;
        while (n < 20) begin
            cycle();
            n++;
            if (state != 3'd2) break;
        end
        chk("tmo.cycles", n, TMO);
        m_begin(); m_state = 4;
        check_all("tmo");
        t_idle();

        // Reset mid-transaction beats a simultaneous note and clears all credit
        t_scan(11, 10); t_mode(1, 0); t_note(100, 0); t_idle();
        t_scan(10, 700); t_mode(1, 0); t_note(100, 0);
        rst = 1'b1; note_vld = 1'b1; note_val = 16'd1000;
        cycle();
        rst = 1'b0;
        m_reset();
        check_all("rst");
        t_scan(11, 50);
        chk("rst.credit_cleared", 32'(bal), 50);
        t_stop(); t_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
